data_memory: RTL and testbench

Block-addressed backing store on the data side of `cpu_pipeline`, directly downstream of the data cache. It serves one 128-bit (16-byte) block per request over the `DATA_MEM_*` port group: `READ`/`WRITE` strobes, a 28-bit block address, and a `BUSYWAIT` handshake. Every access takes a fixed, parameterised latency, which lets the bench model realistic miss penalties and stall the pipeline through the cache's busywait.

---
 rtl/data_memory.sv | 113 +++++++++++
 tb/tb_data_memory.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Block-addressed 128-bit backing store with a fixed-latency BUSYWAIT handshake.
// Optional DATA_MEM_RANGE_CHECK_EN adds out-of-range detection and the sticky ERR port.
module data_memory #(
  parameter int LATENCY = 4,
  parameter int BLOCKS  = 256
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [27:0]  ADDRESS,
  input  logic [127:0] WRITEDATA,
  output logic [127:0] READDATA,
  output logic         BUSYWAIT
`ifdef DATA_MEM_RANGE_CHECK_EN
  ,
  output logic         ERR
`endif
);

  localparam int         IDX_W  = $clog2(BLOCKS);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [7:0]         cnt_r;
  logic [27:0]        addr_r;
  logic [127:0]       wdata_r;
  logic               is_write_r;
  logic [127:0]       readdata_r;
  logic               err_r;
  logic [127:0]       mem_r [BLOCKS];

  logic [IDX_W-1:0]   idx_s;
  logic               in_range_s;
  logic               access_s;

  assign idx_s    = addr_r[IDX_W-1:0];
  assign access_s = (state_r == BUSY) && (cnt_r == 8'd0);

`ifdef DATA_MEM_RANGE_CHECK_EN
  assign in_range_s = ({4'd0, addr_r} < 32'(BLOCKS));
  assign ERR        = err_r;
`else
  // Upper address bits are deliberately dropped: the address wraps modulo BLOCKS.
  logic unused_hi_s;
  assign unused_hi_s = |addr_r[27:IDX_W] | err_r;
  assign in_range_s  = 1'b1;
`endif

  assign READDATA = readdata_r;
  assign BUSYWAIT = ((state_r == IDLE) && (READ || WRITE)) || (state_r == BUSY);

  // Request FSM: accept, count down the latency, then complete the access.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      readdata_r <= 128'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (READ || WRITE) begin
            state_r    <= BUSY;
            addr_r     <= ADDRESS;
            wdata_r    <= WRITEDATA;
            is_write_r <= WRITE;
            cnt_r      <= LAT_M1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            state_r <= DONE;
            if (!is_write_r) begin
              readdata_r <= in_range_s ? mem_r[idx_s] : 128'd0;
            end else begin
              readdata_r <= readdata_r;
            end
            if (!in_range_s) begin
              err_r <= 1'b1;
            end else begin
              err_r <= err_r;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Array update; contents survive reset, but a write abandoned by reset is dropped.
  always_ff @(posedge CLK) begin
    if (RESET && access_s && is_write_r && in_range_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_data_memory;

  localparam int LAT = 4;
  localparam int BLK = 256;

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [27:0]  ADDRESS;
  logic [127:0] WRITEDATA;
  logic [127:0] READDATA;
  logic         BUSYWAIT;
`ifdef DATA_MEM_RANGE_CHECK_EN
  logic         ERR;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] ref_mem [BLK];
  logic [127:0] last_read;
  logic         err_exp;

  data_memory #(.LATENCY(LAT), .BLOCKS(BLK)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
`ifdef DATA_MEM_RANGE_CHECK_EN
    ,
    .ERR       (ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_oob(input logic [27:0] addr);
`ifdef DATA_MEM_RANGE_CHECK_EN
    return (int'(addr) >= BLK);
`else
    return 1'b0;
`endif
  endfunction

  // One full request; called just after a clock edge with the DUT idle.
  task automatic do_req(input logic wr, input logic rd, input logic [27:0] addr,
                        input logic [127:0] data, input logic mid_change);
    int n;
    logic oob;
    oob = model_oob(addr);
    ADDRESS   = addr;
    WRITEDATA = data;
    WRITE     = wr;
    READ      = rd;
    #1;
    check("busywait_on_strobe", {127'd0, BUSYWAIT}, 128'd1);
    n = 1;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK);
      #1;
      if (k == 0 && mid_change) begin
        ADDRESS   = addr + 28'd6;
        WRITEDATA = ~data;
      end
      if (BUSYWAIT !== 1'b1) break;
      n++;
    end
    check("busywait_cycles", 128'(n), 128'(LAT + 1));
    if (wr) begin
      if (!oob) ref_mem[int'(addr) % BLK] = data;
    end else begin
      last_read = oob ? 128'd0 : ref_mem[int'(addr) % BLK];
    end
    if (oob) err_exp = 1'b1;
    check(wr ? "readdata_after_write" : "readdata_in_done", READDATA, last_read);
`ifdef DATA_MEM_RANGE_CHECK_EN
    check("err_in_done", {127'd0, ERR}, {127'd0, err_exp});
`endif
    READ  = 1'b0;
    WRITE = 1'b0;
    @(posedge CLK);
    #1;
    check("idle_after_done", {127'd0, BUSYWAIT}, 128'd0);
    check("readdata_hold", READDATA, last_read);
  endtask

  initial begin
    logic [127:0] d;
    logic [27:0]  a;
    int           sel;

    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    ADDRESS = 28'd0; WRITEDATA = 128'd0;
    last_read = 128'd0;
    err_exp   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_readdata", READDATA, 128'd0);
    check("reset_busywait", {127'd0, BUSYWAIT}, 128'd0);
`ifdef DATA_MEM_RANGE_CHECK_EN
    check("reset_err", {127'd0, ERR}, 128'd0);
`endif
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Give every block a known value.
    for (int i = 0; i < BLK; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      do_req(1'b1, 1'b0, 28'(i), d, 1'b0);
    end

    do_req(1'b1, 1'b0, 28'h0000005, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    do_req(1'b0, 1'b1, 28'h0000005, 128'd0, 1'b0);
    check("directed_read_5", READDATA, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Both strobes: treated as a write.
    do_req(1'b1, 1'b1, 28'h0000007, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0007, 1'b0);
    do_req(1'b0, 1'b1, 28'h0000007, 128'd0, 1'b0);

    // Address/data changed mid-BUSY: only block 3 updates.
    do_req(1'b1, 1'b0, 28'h0000003, 128'h3333_3333_CAFE_F00D_3333_3333_BEEF_0003, 1'b1);
    do_req(1'b0, 1'b1, 28'h0000009, 128'd0, 1'b0);
    do_req(1'b0, 1'b1, 28'h0000003, 128'd0, 1'b0);

    // Reset in the second BUSY cycle of a write to block 2.
    ADDRESS = 28'h0000002; WRITEDATA = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_0002; WRITE = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0; WRITE = 1'b0;
    @(posedge CLK); #1;
    check("midreset_busywait", {127'd0, BUSYWAIT}, 128'd0);
    check("midreset_readdata", READDATA, 128'd0);
    last_read = 128'd0;
    err_exp   = 1'b0;
    RESET = 1'b1;
    do_req(1'b0, 1'b1, 28'h0000002, 128'd0, 1'b0);

    // Address beyond BLOCKS: wraps, or flagged when range checking is built in.
    do_req(1'b1, 1'b0, 28'h0000105, 128'h0105_0105_0105_0105_0105_0105_0105_0105, 1'b0);
    do_req(1'b0, 1'b1, 28'h0000005, 128'd0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 7);
      a   = (sel == 0) ? 28'($urandom) : 28'($urandom_range(0, BLK - 1));
      d   = {$urandom, $urandom, $urandom, $urandom};
      sel = $urandom_range(0, 4);
      do_req((sel < 2) || (sel == 4), sel >= 2, a, d, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
